rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single combinational read port of the boot ROM (byte-addressed, little-endian, window 0xBFC00000–0xBFC00FFF) between two requesters: instruction fetch (IF) and the load unit (LS, for constant/literal loads).
- Fixed LS priority, with an anti-starvation counter that forces an IF grant after a bounded wait.
- Responses are registered: one-cycle latency, range and alignment checks, and a fetch-flush path for redirects.

Parameters:
- DATA_WIDTH, 32, ROM word width.
- ADDRESS_WIDTH, 32, address width.
- ROM_BASE, 32'hBFC00000, first valid byte address.
- ROM_BYTES, 4096, window size in bytes.
- STARVE_MAX, 4, consecutive LS-won cycles while IF is requesting, after which IF is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF request valid.
- if_addr  in  ADDRESS_WIDTH  IF byte address.
- if_flush  in  1  kill the IF response issued from the previous cycle.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF response valid.
- if_rdata  out  DATA_WIDTH  IF response word.
- if_err  out  1  IF response is an error (range or alignment).
- ls_req  in  1  LS request valid.
- ls_addr  in  ADDRESS_WIDTH  LS byte address.
- ls_gnt  out  1  LS request accepted this cycle (combinational).
- ls_rvalid  out  1  LS response valid.
- ls_rdata  out  DATA_WIDTH  LS response word.
- ls_err  out  1  LS response error.
- mem_a  out  ADDRESS_WIDTH  address to the ROM.
- mem_rd  in  DATA_WIDTH  ROM read data, combinational from mem_a.

Behaviour:
- Reset (async, rst_n low):
  - all rvalid/err = 0; rdata = 0; starvation counter = 0.
  - Outputs go low immediately on rst_n falling, with no clock needed.
  - Any in-flight response is dropped and never reappears after reset.
- Arbitration (combinational, every cycle):
  - force_if = (starve_cnt == STARVE_MAX).
  - ls_gnt = ls_req & ~(force_if & if_req).
  - if_gnt = if_req & ~ls_gnt.
  - At most one grant per cycle.
- mem_a:
  - equals ls_addr if ls_gnt, otherwise if_addr.
  - When idle it is driven with if_addr; no X.
- Starvation counter (saturating, 0..STARVE_MAX):
  - +1 when if_req & ls_gnt.
  - Cleared when if_gnt.
  - Holds when if_req = 0.
- Checks, on the granted address:
  - in_range = (addr >= ROM_BASE) & (addr <= ROM_BASE + ROM_BYTES − 4).
  - aligned = (addr[1:0] == 0).
  - err = ~(in_range & aligned).
  - Comparisons are unsigned, at full ADDRESS_WIDTH; no wrap.
- Response (cycle N grant → cycle N+1 valid):
  - The granted side's rvalid is 1 for exactly one cycle.
  - rdata = mem_rd sampled at the N edge, or 0 if err.
  - err registered alongside.
  - Ungranted side's rvalid = 0.
- Back-to-back: a requester holding req is granted every cycle it wins, giving one response per cycle; there is no bubble.
- Flush:
  - if_flush high in cycle N+1 forces if_rvalid = 0 in N+1 (combinational mask).
  - if_flush together with if_req in the same cycle: the new request is still arbitrated normally; flush only kills the already-registered response.
- No backpressure on responses: requesters must accept rvalid on the cycle it is asserted.
- rdata holds its last value when rvalid = 0.

Decomposition:
- Shared package rom_pkg:
  - ROM_BASE and ROM_BYTES localparams (also used by the ROM and the address decoder).
  - typedef enum requester_t {REQ_IF, REQ_LS}, used for the registered "owner" of the response.
- One natural sub-module: rom_range_chk (combinational in_range/aligned/err from an address), reused by the data-memory decoder.

Test Plan:
- IF only, addr 0xBFC00000, ROM word 0x00500093 → if_gnt = 1 at N; if_rvalid = 1, if_rdata = 0x00500093, if_err = 0 at N+1; ls_rvalid = 0.
- Both request (IF 0xBFC00004, LS 0xBFC00010) → ls_gnt = 1, if_gnt = 0, mem_a = 0xBFC00010; LS response at N+1; IF granted at N+1 once LS drops.
- LS and IF both request continuously with STARVE_MAX = 4 → LS granted 4 cycles, IF granted on cycle 5, counter back to 0, pattern repeats.
- Out of range and misaligned:
  - LS addr 0xBFC01000 → ls_err = 1, ls_rdata = 0.
  - IF addr 0xBFC00002 → if_err = 1.
  - Addr 0xBFC00FFC → valid.
- Flush: IF granted at 0xBFC00008 at N, if_flush = 1 at N+1 → if_rvalid stays 0; a new IF request at N+1 still gets a response at N+2.
- Reset: assert rst_n = 0 mid-cycle while LS response pending → ls_rvalid drops before the next clk edge; after release, no stale response appears and the counter is 0.

Source files
------------

// File: rtl/rom_pkg.sv
// Boot ROM window constants and the response-owner type shared by the
// arbiter, the range checker and the data-memory decoder.
package rom_pkg;

  localparam logic [31:0] ROM_BASE  = 32'hBFC0_0000;
  localparam int unsigned ROM_BYTES = 4096;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } requester_t;

endpackage : rom_pkg

// File: rtl/rom_range_chk.sv
// Combinational window and word-alignment check for a byte address.
// Shared with the data-memory decoder, so it has no knowledge of requesters.
module rom_range_chk #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   ROM_BASE      = rom_pkg::ROM_BASE,
  parameter int unsigned                ROM_BYTES     = rom_pkg::ROM_BYTES
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     in_range,
  output logic                     aligned,
  output logic                     err
);

  // One extra bit keeps the upper bound from wrapping near the top of memory.
  localparam logic [ADDRESS_WIDTH:0] BASE_X = {1'b0, ROM_BASE};
  localparam logic [ADDRESS_WIDTH:0] LAST_X = BASE_X + (ADDRESS_WIDTH+1)'(ROM_BYTES - 4);

  logic [ADDRESS_WIDTH:0] addr_x;

  assign addr_x   = {1'b0, addr};
  assign in_range = (addr_x >= BASE_X) && (addr_x <= LAST_X);
  assign aligned  = (addr[1:0] == 2'b00);
  assign err      = ~(in_range & aligned);

endmodule : rom_range_chk

// File: rtl/rom_arbiter.sv
// Shares the combinational boot-ROM read port between instruction fetch and
// the load unit: LS priority with a starvation limit, one-cycle responses.
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_BASE      = rom_pkg::ROM_BASE,
  parameter int unsigned              ROM_BYTES     = rom_pkg::ROM_BYTES,
  parameter int unsigned              STARVE_MAX    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  input  logic                     if_flush,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_err,

  input  logic                     ls_req,
  input  logic [ADDRESS_WIDTH-1:0] ls_addr,
  output logic                     ls_gnt,
  output logic                     ls_rvalid,
  output logic [DATA_WIDTH-1:0]    ls_rdata,
  output logic                     ls_err,

  output logic [ADDRESS_WIDTH-1:0] mem_a,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]      starve_cnt_reg;
  logic                  force_if;

  logic                  chk_in_range;
  logic                  chk_aligned;
  logic                  chk_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  rsp_valid_reg;
  requester_t            rsp_owner_reg;
  logic [DATA_WIDTH-1:0] if_rdata_reg;
  logic                  if_err_reg;
  logic [DATA_WIDTH-1:0] ls_rdata_reg;
  logic                  ls_err_reg;

  // Arbitration: LS wins unless IF has been passed over STARVE_MAX times.
  assign force_if = (starve_cnt_reg == CNT_MAX);
  assign ls_gnt   = ls_req & ~(force_if & if_req);
  assign if_gnt   = if_req & ~ls_gnt;
  assign mem_a    = ls_gnt ? ls_addr : if_addr;

  rom_range_chk #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .ROM_BASE      (ROM_BASE),
    .ROM_BYTES     (ROM_BYTES)
  ) u_range_chk (
    .addr     (mem_a),
    .in_range (chk_in_range),
    .aligned  (chk_aligned),
    .err      (chk_err)
  );

  // Faulting accesses return zero so ROM contents never leak on an error.
  assign rsp_data = (chk_in_range & chk_aligned) ? mem_rd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (if_gnt) begin
      starve_cnt_reg <= '0;
    end else if (if_req && ls_gnt && (starve_cnt_reg != CNT_MAX)) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  // Each side keeps its own data/err so rdata holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_owner_reg <= REQ_IF;
      if_rdata_reg  <= '0;
      if_err_reg    <= 1'b0;
      ls_rdata_reg  <= '0;
      ls_err_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= if_gnt | ls_gnt;
      if (ls_gnt) begin
        rsp_owner_reg <= REQ_LS;
        ls_rdata_reg  <= rsp_data;
        ls_err_reg    <= chk_err;
      end else if (if_gnt) begin
        rsp_owner_reg <= REQ_IF;
        if_rdata_reg  <= rsp_data;
        if_err_reg    <= chk_err;
      end
    end
  end

  // Flush masks only the response already in flight, never a new grant.
  assign if_rvalid = rsp_valid_reg & (rsp_owner_reg == REQ_IF) & ~if_flush;
  assign ls_rvalid = rsp_valid_reg & (rsp_owner_reg == REQ_LS);
  assign if_rdata  = if_rdata_reg;
  assign if_err    = if_err_reg;
  assign ls_rdata  = ls_rdata_reg;
  assign ls_err    = ls_err_reg;

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// Directed vector bench for rom_arbiter with a small word-indexed ROM model.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] if_rdata, ls_rdata, mem_a, mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rom [0:1023];

  always #5 clk = ~clk;

  // ROM model: word i holds 0x10000000+i, except word 0; outside the window
  // it returns a poison value that must never reach a requester.
  always_comb begin
    if (mem_a >= 32'hBFC0_0000 && mem_a < 32'hBFC0_1000)
      mem_rd = rom[mem_a[11:2]];
    else
      mem_rd = 32'hDEAD_BEEF;
  end

  rom_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ls_err    (ls_err),
    .mem_a     (mem_a),
    .mem_rd    (mem_rd)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        lsr;
    logic [31:0] lsa;
    logic        fl;
    logic        e_ifg;
    logic        e_lsg;
    logic [31:0] e_mema;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_ife;
    logic        e_lsv;
    logic [31:0] e_lsd;
    logic        e_lse;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic lsr,
                       input logic [31:0] lsa, input logic fl);
    if_req   = ifr;
    if_addr  = ifa;
    ls_req   = lsr;
    ls_addr  = lsa;
    if_flush = fl;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + i;
    rom[0] = 32'h0050_0093;

    //          ifr ifa           lsr lsa           fl ifg lsg mem_a         ifv if_rdata      ife lsv ls_rdata      lse
    vecs[0]  = '{1, 32'hBFC00000, 0, 32'h0,        0, 1,  0,  32'hBFC00000, 0,  32'h0,        0,  0,  32'h0,        0};
    vecs[1]  = '{0, 32'hBFC00000, 0, 32'h0,        0, 0,  0,  32'hBFC00000, 1,  32'h00500093, 0,  0,  32'h0,        0};
    vecs[2]  = '{1, 32'hBFC00004, 1, 32'hBFC00010, 0, 0,  1,  32'hBFC00010, 0,  32'h0,        0,  0,  32'h0,        0};
    vecs[3]  = '{1, 32'hBFC00004, 0, 32'h0,        0, 1,  0,  32'hBFC00004, 0,  32'h0,        0,  1,  32'h10000004, 0};
    vecs[4]  = '{0, 32'hBFC00004, 1, 32'hBFC01000, 0, 0,  1,  32'hBFC01000, 1,  32'h10000001, 0,  0,  32'h0,        0};
    vecs[5]  = '{1, 32'hBFC00002, 0, 32'h0,        0, 1,  0,  32'hBFC00002, 0,  32'h0,        0,  1,  32'h0,        1};
    vecs[6]  = '{0, 32'hBFC00002, 1, 32'hBFC00FFC, 0, 0,  1,  32'hBFC00FFC, 1,  32'h0,        1,  0,  32'h0,        0};
    vecs[7]  = '{0, 32'hBFC00000, 0, 32'h0,        0, 0,  0,  32'hBFC00000, 0,  32'h0,        0,  1,  32'h100003FF, 0};
    vecs[8]  = '{1, 32'hBFC00008, 1, 32'hBFC0000C, 0, 0,  1,  32'hBFC0000C, 0,  32'h0,        0,  0,  32'h0,        0};
    vecs[9]  = '{1, 32'hBFC00008, 1, 32'hBFC0000C, 0, 0,  1,  32'hBFC0000C, 0,  32'h0,        0,  1,  32'h10000003, 0};
    vecs[10] = '{1, 32'hBFC00008, 1, 32'hBFC0000C, 0, 0,  1,  32'hBFC0000C, 0,  32'h0,        0,  1,  32'h10000003, 0};
    vecs[11] = '{1, 32'hBFC00008, 1, 32'hBFC0000C, 0, 0,  1,  32'hBFC0000C, 0,  32'h0,        0,  1,  32'h10000003, 0};
    vecs[12] = '{1, 32'hBFC00008, 1, 32'hBFC0000C, 0, 1,  0,  32'hBFC00008, 0,  32'h0,        0,  1,  32'h10000003, 0};
    vecs[13] = '{1, 32'hBFC00008, 1, 32'hBFC0000C, 0, 0,  1,  32'hBFC0000C, 1,  32'h10000002, 0,  0,  32'h0,        0};
    vecs[14] = '{1, 32'hBFC00008, 0, 32'h0,        0, 1,  0,  32'hBFC00008, 0,  32'h0,        0,  1,  32'h10000003, 0};
    vecs[15] = '{1, 32'hBFC00004, 0, 32'h0,        1, 1,  0,  32'hBFC00004, 0,  32'h0,        0,  0,  32'h0,        0};
    vecs[16] = '{0, 32'hBFC00004, 0, 32'h0,        0, 0,  0,  32'hBFC00004, 1,  32'h10000001, 0,  0,  32'h0,        0};
    vecs[17] = '{0, 32'hBFC00004, 0, 32'h0,        0, 0,  0,  32'hBFC00004, 0,  32'h0,        0,  0,  32'h0,        0};

    rst_n = 1'b0;
    drive(0, 32'h0, 0, 32'h0, 0);
    #3;
    check("reset if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check("reset ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    check("reset if_rdata",  if_rdata, 32'h0);
    check("reset ls_rdata",  ls_rdata, 32'h0);
    check("reset if_err",    {31'b0, if_err}, 32'd0);
    check("reset ls_err",    {31'b0, ls_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].ifr, vecs[i].ifa, vecs[i].lsr, vecs[i].lsa, vecs[i].fl);
      @(negedge clk);
      check($sformatf("row%0d if_gnt", i), {31'b0, if_gnt}, {31'b0, vecs[i].e_ifg});
      check($sformatf("row%0d ls_gnt", i), {31'b0, ls_gnt}, {31'b0, vecs[i].e_lsg});
      check($sformatf("row%0d mem_a", i), mem_a, vecs[i].e_mema);
      check($sformatf("row%0d if_rvalid", i), {31'b0, if_rvalid}, {31'b0, vecs[i].e_ifv});
      check($sformatf("row%0d ls_rvalid", i), {31'b0, ls_rvalid}, {31'b0, vecs[i].e_lsv});
      if (vecs[i].e_ifv) begin
        check($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].e_ifd);
        check($sformatf("row%0d if_err", i), {31'b0, if_err}, {31'b0, vecs[i].e_ife});
      end
      if (vecs[i].e_lsv) begin
        check($sformatf("row%0d ls_rdata", i), ls_rdata, vecs[i].e_lsd);
        check($sformatf("row%0d ls_err", i), {31'b0, ls_err}, {31'b0, vecs[i].e_lse});
      end
    end
    check("hold if_rdata", if_rdata, 32'h1000_0001);

    // Build up starvation, then reset mid-cycle while an LS response is live.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      drive(1, 32'hBFC00008, 1, 32'hBFC0000C, 0);
    end
    @(posedge clk);
    #1;
    drive(0, 32'hBFC00008, 0, 32'h0, 0);
    check("pre-reset ls_rvalid", {31'b0, ls_rvalid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    check("async ls_rdata", ls_rdata, 32'h0);
    check("async if_rvalid", {31'b0, if_rvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    check("post-reset if_rvalid", {31'b0, if_rvalid}, 32'd0);

    // A cleared counter lets LS win exactly four times before IF is forced.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      drive(1, 32'hBFC00008, 1, 32'hBFC0000C, 0);
      @(negedge clk);
      check($sformatf("starve%0d ls_gnt", k), {31'b0, ls_gnt}, (k < 4) ? 32'd1 : 32'd0);
      check($sformatf("starve%0d if_gnt", k), {31'b0, if_gnt}, (k < 4) ? 32'd0 : 32'd1);
    end

    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 32'h0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rom_arbiter
